// File: rtl/wave_controller.sv
// Wave/difficulty controller: spawn pacing, kill-driven levelling, scoring and
// lives for a single-ship shooter, sequenced by an IDLE/PLAY/HIT/OVER FSM.
module wave_controller #(
  parameter int unsigned SPAWN_BASE      = 60,
  parameter int unsigned SPAWN_STEP      = 4,
  parameter int unsigned SPAWN_MIN       = 8,
  parameter int unsigned KILLS_PER_LEVEL = 10,
  parameter int unsigned MAX_ENEMIES     = 8,
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned HIT_FRAMES      = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [3:0]  enemy_count,
  input  logic [3:0]  kill_count,
  input  logic        collision,
  output logic        spawn,
  output logic        playing,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [15:0] score,
  output logic [1:0]  lives
);

  localparam int unsigned TMAX = (SPAWN_BASE > SPAWN_MIN) ? SPAWN_BASE : SPAWN_MIN;
  localparam int unsigned TW   = $clog2(TMAX + 2);
  localparam int unsigned HW   = $clog2(HIT_FRAMES + 2);
  localparam int unsigned AW   = $clog2(KILLS_PER_LEVEL + 16);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_e;

  state_e        state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [3:0]    level_q, level_d;
  logic [1:0]    lives_q, lives_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hit_q, hit_d;
  logic          spawn_q, spawn_d;

  logic [16:0]   score_sum;
  logic [15:0]   score_next;
  logic [AW:0]   acc_sum;
  logic [AW-1:0] acc_sat;
  logic [AW-1:0] acc_next;
  logic [3:0]    level_next;

  // Signed arithmetic so a high level clamps to SPAWN_MIN instead of wrapping.
  function automatic logic [TW-1:0] interval(input logic [3:0] lvl);
    int iv;
    iv = int'(SPAWN_BASE) - int'(lvl) * int'(SPAWN_STEP);
    if (iv < int'(SPAWN_MIN)) iv = int'(SPAWN_MIN);
    return TW'(iv);
  endfunction

  always_comb begin
    score_sum  = {1'b0, score_q} + {13'b0, kill_count};
    score_next = score_sum[16] ? '1 : score_sum[15:0];
    // Accumulator saturates so a sustained kill flood cannot wrap it.
    acc_sum    = {1'b0, acc_q} + (AW + 1)'(kill_count);
    acc_sat    = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
    acc_next   = acc_sat;
    level_next = level_q;
    if (32'(acc_sat) >= KILLS_PER_LEVEL) begin
      acc_next   = AW'(32'(acc_sat) - KILLS_PER_LEVEL);
      level_next = (level_q == 4'hF) ? level_q : level_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    level_d = level_q;
    lives_d = lives_q;
    acc_d   = acc_q;
    timer_d = timer_q;
    hit_d   = hit_q;
    spawn_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          score_d = '0;
          level_d = '0;
          lives_d = 2'(START_LIVES);
          acc_d   = '0;
          timer_d = TW'(SPAWN_BASE);
          hit_d   = '0;
        end
      end
      S_PLAY: begin
        score_d = score_next;
        acc_d   = acc_next;
        level_d = level_next;
        if (collision) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            hit_d   = HW'(HIT_FRAMES);
            state_d = S_HIT;
          end else begin
            lives_d = '0;
            state_d = S_OVER;
          end
        end else if (frame_tick) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (32'(enemy_count) < MAX_ENEMIES) begin
            spawn_d = 1'b1;
            timer_d = interval(level_q);
          end
        end
      end
      S_HIT: begin
        score_d = score_next;
        acc_d   = acc_next;
        level_d = level_next;
        if (frame_tick) begin
          if (hit_q <= HW'(1)) begin
            hit_d   = '0;
            state_d = S_PLAY;
          end else begin
            hit_d = hit_q - HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      score_q <= '0;
      level_q <= '0;
      lives_q <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      hit_q   <= '0;
      spawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      level_q <= level_d;
      lives_q <= lives_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
      spawn_q <= spawn_d;
    end
  end

  assign spawn     = spawn_q;
  assign playing   = (state_q == S_PLAY) || (state_q == S_HIT);
  assign game_over = (state_q == S_OVER);
  assign level     = level_q;
  assign score     = score_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_wave_controller.sv
// Scoreboard bench for wave_controller: stimulus queues expected snapshots and
// spawn cycles; a negedge monitor pops and compares them against the outputs.
module tb_wave_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  enemy_count = '0;
  logic [3:0]  kill_count = '0;
  logic        collision = 1'b0;
  logic        spawn;
  logic        playing;
  logic        game_over;
  logic [3:0]  level;
  logic [15:0] score;
  logic [1:0]  lives;

  typedef struct {
    string       name;
    logic [15:0] score;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic        playing;
    logic        game_over;
  } snap_t;

  snap_t       snap_q[$];
  int unsigned spawn_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cycle = 0;

  wave_controller #(
    .SPAWN_BASE(60), .SPAWN_STEP(4), .SPAWN_MIN(8), .KILLS_PER_LEVEL(10),
    .MAX_ENEMIES(8), .START_LIVES(3), .HIT_FRAMES(90)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .enemy_count(enemy_count), .kill_count(kill_count), .collision(collision),
    .spawn(spawn), .playing(playing), .game_over(game_over),
    .level(level), .score(score), .lives(lives)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin : monitor
    snap_t       s;
    int unsigned exp_cyc;
    while (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      checks++;
      if ({score, level, lives, playing, game_over} !==
          {s.score, s.level, s.lives, s.playing, s.game_over}) begin
        errors++;
        $display("FAIL %s: got score=%0d level=%0d lives=%0d playing=%0b game_over=%0b, want score=%0d level=%0d lives=%0d playing=%0b game_over=%0b",
                 s.name, score, level, lives, playing, game_over,
                 s.score, s.level, s.lives, s.playing, s.game_over);
      end
    end
    if (spawn === 1'b1) begin
      checks++;
      if (spawn_q.size() == 0) begin
        errors++;
        $display("FAIL spawn_unexpected: got spawn=1 at cycle %0d, want no spawn", cycle);
      end else begin
        exp_cyc = spawn_q.pop_front();
        if (exp_cyc != cycle) begin
          errors++;
          $display("FAIL spawn_cycle: got spawn at cycle %0d, want cycle %0d", cycle, exp_cyc);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit exp_spawn);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    if (exp_spawn) spawn_q.push_back(cycle);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic expect_snap(input string nm, input logic [15:0] sc, input logic [3:0] lv,
                             input logic [1:0] li, input logic p, input logic g);
    snap_t s;
    s.name = nm; s.score = sc; s.level = lv; s.lives = li; s.playing = p; s.game_over = g;
    snap_q.push_back(s);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    cyc(); cyc();
    expect_snap("reset_state", 16'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ticks(5);
    expect_snap("idle_no_start", 16'd0, 4'd0, 2'd0, 1'b0, 1'b0);

    // First spawn one cycle after tick 61, then a full 60-frame reload.
    start = 1'b1; cyc(); start = 1'b0;
    expect_snap("start", 16'd0, 4'd0, 2'd3, 1'b1, 1'b0);
    ticks(60); tick(1'b1);
    ticks(60); tick(1'b1);

    // 3x4 kills: score 12, level 1, accumulator 2; interval becomes 56.
    kill_count = 4'd4; cyc(); cyc(); cyc(); kill_count = '0;
    expect_snap("kills_level1", 16'd12, 4'd1, 2'd3, 1'b1, 1'b0);
    ticks(60); tick(1'b1);
    ticks(56); tick(1'b1);

    // Pool full at the due tick: retry until a slot frees up.
    ticks(56);
    enemy_count = 4'd8; tick(1'b0); tick(1'b0);
    enemy_count = 4'd7; tick(1'b1);
    enemy_count = '0;

    // Collision on a spawn-due tick wins; HIT lasts exactly 90 ticks.
    ticks(56);
    collision = 1'b1; frame_tick = 1'b1; cyc(); collision = 1'b0; frame_tick = 1'b0;
    expect_snap("collision1", 16'd12, 4'd1, 2'd2, 1'b1, 1'b0);
    collision = 1'b1; kill_count = 4'd3; cyc(); collision = 1'b0; kill_count = '0;
    expect_snap("collision_in_hit", 16'd15, 4'd1, 2'd2, 1'b1, 1'b0);
    ticks(90); tick(1'b1);
    expect_snap("hit_expired", 16'd15, 4'd1, 2'd2, 1'b1, 1'b0);

    collision = 1'b1; cyc(); collision = 1'b0;
    expect_snap("collision2", 16'd15, 4'd1, 2'd1, 1'b1, 1'b0);
    ticks(90);
    collision = 1'b1; kill_count = 4'd5; cyc(); collision = 1'b0; kill_count = '0;
    expect_snap("collision3_over", 16'd20, 4'd2, 2'd0, 1'b0, 1'b1);
    kill_count = 4'd7; tick(1'b0); tick(1'b0); kill_count = '0;
    expect_snap("over_frozen", 16'd20, 4'd2, 2'd0, 1'b0, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    expect_snap("restart", 16'd0, 4'd0, 2'd3, 1'b1, 1'b0);

    // Score 500 (level saturates at 15), enter HIT, then async reset.
    kill_count = 4'd15;
    for (int i = 0; i < 33; i++) cyc();
    kill_count = 4'd5; cyc(); kill_count = '0;
    expect_snap("score_500", 16'd500, 4'd15, 2'd3, 1'b1, 1'b0);
    collision = 1'b1; cyc(); collision = 1'b0;
    expect_snap("hit_500", 16'd500, 4'd15, 2'd2, 1'b1, 1'b0);
    ticks(5);
    #1;
    rst_n = 1'b0;
    expect_snap("async_reset", 16'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;
    ticks(70);
    expect_snap("idle_after_reset", 16'd0, 4'd0, 2'd0, 1'b0, 1'b0);

    // Score saturation at 16'hFFFF.
    start = 1'b1; cyc(); start = 1'b0;
    kill_count = 4'd15;
    for (int i = 0; i < 4368; i++) cyc();
    kill_count = 4'd14; cyc();
    expect_snap("score_65534", 16'hFFFE, 4'd15, 2'd3, 1'b1, 1'b0);
    kill_count = 4'd15; cyc(); kill_count = '0;
    expect_snap("score_saturate", 16'hFFFF, 4'd15, 2'd3, 1'b1, 1'b0);

    cyc(); cyc();
    while (spawn_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL spawn_missing: got no spawn, want spawn at cycle %0d", spawn_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_controller.md
WAVE_CONTROLLER -- requirements
Module: wave_controller

Interface
REQ-001 Parameter SPAWN_BASE, default 60: spawn interval in frames at level 0.
REQ-002 Parameter SPAWN_STEP, default 4: frames removed from the interval per level.
REQ-003 Parameter SPAWN_MIN, default 8: floor on the spawn interval in frames.
REQ-004 Parameter KILLS_PER_LEVEL, default 10: kills needed to advance one level.
REQ-005 Parameter MAX_ENEMIES, default 8: no spawn is requested while enemy_count >= MAX_ENEMIES.
REQ-006 Parameter START_LIVES, default 3; parameter HIT_FRAMES, default 90 (invulnerability length in frames).
REQ-007 clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 start  in  1  level-sensitive start/restart request.
REQ-011 enemy_count  in  4  live enemies reported by the enemy pool.
REQ-012 kill_count  in  4  kills reported by the enemy pool in this cycle.
REQ-013 collision  in  1  an enemy reached the ship in this cycle.
REQ-014 spawn  out  1  registered one-cycle spawn request to the enemy pool.
REQ-015 playing  out  1  high in the PLAY and HIT states.
REQ-016 game_over  out  1  high in the OVER state.
REQ-017 level  out  4;  score  out  16;  lives  out  2.

Function
REQ-018 The FSM SHALL have four states: IDLE, PLAY, HIT and OVER; playing and game_over are decoded from the state register.
REQ-019 In IDLE or OVER, start=1 SHALL move to PLAY on the next edge and load: score=0, level=0, lives=START_LIVES, kill accumulator=0, spawn timer=SPAWN_BASE.
REQ-020 In PLAY or HIT, start SHALL be ignored.
REQ-021 Interval(level) SHALL be max(SPAWN_BASE - level*SPAWN_STEP, SPAWN_MIN), computed without unsigned underflow.
REQ-022 In PLAY, each frame_tick with timer>0 SHALL decrement the timer.
REQ-023 In PLAY, a frame_tick with timer==0 and enemy_count<MAX_ENEMIES SHALL raise spawn for exactly the next cycle and reload the timer with Interval(level).
REQ-024 If enemy_count>=MAX_ENEMIES at that tick, the timer SHALL stay at 0, no spawn is issued, and the spawn is retried on each later tick.
REQ-025 In PLAY and HIT, score SHALL add kill_count every cycle and saturate at 16'hFFFF.
REQ-026 The kill accumulator SHALL add kill_count every cycle (PLAY and HIT).
REQ-027 When the accumulator reaches KILLS_PER_LEVEL or more, it SHALL subtract KILLS_PER_LEVEL and level SHALL increment by 1, at most once per cycle; level saturates at 15.
REQ-028 Collision in PLAY with lives>1 SHALL decrement lives, enter HIT and load the hit counter with HIT_FRAMES.
REQ-029 Collision in PLAY with lives==1 SHALL set lives=0 and enter OVER.
REQ-030 In HIT, the spawn timer SHALL freeze, spawn SHALL stay 0 and collision SHALL be ignored.
REQ-031 In HIT, each frame_tick SHALL decrement the hit counter; reaching 0 SHALL return the FSM to PLAY.
REQ-032 Collision and a spawn-due frame_tick in the same cycle: collision wins, no spawn is issued, and the timer stays at 0.
REQ-033 Kills arriving in the same cycle as a collision SHALL still be scored.
REQ-034 In OVER, score, level and lives SHALL hold, and spawn SHALL be 0.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE and spawn=0, playing=0, game_over=0, level=0, score=0, lives=0, with all timers and the accumulator cleared, regardless of the current state.
REQ-036 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-037 Start pulse, then 61 frame_ticks with enemy_count=0 -> exactly one spawn pulse, one cycle after tick 61; timer reloads to 60.
REQ-038 kill_count=4 for 3 cycles at level 0 -> score=12, level=1, accumulator=2; next interval=56.
REQ-039 enemy_count=8 at the due tick -> no spawn; set enemy_count=7 before the next tick -> spawn follows that tick.
REQ-040 Three collisions, each after the HIT window expires -> lives 3,2,1,0; game_over=1 and score frozen; start -> score=0, lives=3.
REQ-041 Collision during HIT -> lives unchanged; after 90 ticks playing=1, FSM back in PLAY.
REQ-042 rst_n low mid-HIT with score=500 -> all outputs 0 asynchronously; no spawn after release without start.
